// File: rtl/cliff_game_seq.sv
// cliff_game_seq: sequencing controller for the cliff game datapath.
//
// It owns the game FSM (IDLE / RUN / LOST), the speed-dependent move tick,
// the position of the 3-wide people group, the cliff boundary decode, lose
// detection and scoring. Everything runs on a single clock domain, clk.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   start_p            start / abort pulse
//   left_p, right_p    move (IDLE) or direction (RUN) pulses
//   up_p, down_p       speed up / down pulses (saturating 0..2)
//   edge_hi, edge_lo   left / right cliff depth
//   led                people | boundaries
//   state              0=IDLE 1=RUN 2=LOST
//   speed, score, lose status outputs
//
// Optional build macro: CLIFF_BLINK_EN. When it is defined, the people bits
// blink in LOST with a half-period of TICK_FAST.
module cliff_game_seq #(
  parameter int unsigned TICK_SLOW = 50000000,
  parameter int unsigned TICK_MED  = 12500000,
  parameter int unsigned TICK_FAST = 5000000,
  parameter int unsigned START_IDX = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_p,
  input  logic        left_p,
  input  logic        right_p,
  input  logic        up_p,
  input  logic        down_p,
  input  logic [2:0]  edge_hi,
  input  logic [2:0]  edge_lo,
  output logic [15:0] led,
  output logic [1:0]  state,
  output logic [1:0]  speed,
  output logic [15:0] score,
  output logic        lose
);

  localparam int CW = $clog2(TICK_SLOW + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LOST = 2'd2} state_e;
  typedef enum logic [1:0] {STOP = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} dir_e;

  state_e        state_q, state_d;
  dir_e          dir_q, dir_d;
  logic [3:0]    pos_q, pos_d;
  logic [1:0]    speed_q, speed_d;
  logic [15:0]   score_q, score_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [4:0]    hi, lo;
  logic          lose_cond;
  logic          blink;

  function automatic logic [CW-1:0] period_m1(input logic [1:0] s);
    case (s)
      2'd0:    return CW'(TICK_SLOW - 1);
      2'd1:    return CW'(TICK_MED - 1);
      default: return CW'(TICK_FAST - 1);
    endcase
  endfunction

  // Lose check on the registered position; edges may change at any time.
  assign hi        = 5'd15 - {2'b00, edge_hi};
  assign lo        = {2'b00, edge_lo};
  assign lose_cond = ({1'b0, pos_q} >= hi) || ({1'b0, pos_q} <= lo);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= STOP;
      pos_q   <= 4'(START_IDX);
      speed_q <= 2'd0;
      score_q <= 16'd0;
      cnt_q   <= CW'(TICK_SLOW - 1);
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      speed_q <= speed_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    score_d = score_q;
    cnt_d   = cnt_q;

    // Speed is live in every state; a new period only takes effect at reload.
    speed_d = speed_q;
    if (up_p) begin
      if (speed_q < 2'd2) speed_d = speed_q + 2'd1;
    end else if (down_p) begin
      if (speed_q != 2'd0) speed_d = speed_q - 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (start_p) begin
          state_d = RUN;
          dir_d   = STOP;
          score_d = 16'd0;
          cnt_d   = period_m1(speed_q);
        end else if (left_p) begin
          if (pos_q < 4'd14) pos_d = pos_q + 4'd1;
        end else if (right_p) begin
          if (pos_q > 4'd1) pos_d = pos_q - 4'd1;
        end
      end
      RUN: begin
        // Losing freezes everything, including a tick due this cycle.
        if (lose_cond) begin
          state_d = LOST;
        end else if (start_p) begin
          state_d = IDLE;
          pos_d   = 4'(START_IDX);
          dir_d   = STOP;
        end else begin
          if (left_p)       dir_d = LEFT;
          else if (right_p) dir_d = RIGHT;
          if (cnt_q == '0) begin
            cnt_d = period_m1(speed_q);
            if (dir_q != STOP) begin
              if (dir_q == LEFT && pos_q != 4'd15) pos_d = pos_q + 4'd1;
              if (dir_q == RIGHT && pos_q != 4'd0) pos_d = pos_q - 4'd1;
              if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      LOST: begin
        if (start_p) begin
          state_d = IDLE;
          pos_d   = 4'(START_IDX);
          dir_d   = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CLIFF_BLINK_EN
  localparam int BW = $clog2(TICK_FAST + 1);
  logic          blink_q;
  logic [BW-1:0] bcnt_q;

  // Free-running half-period counter, restarted on every entry into LOST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_q <= 1'b0;
      bcnt_q  <= BW'(TICK_FAST - 1);
    end else if (state_q != LOST) begin
      blink_q <= 1'b0;
      bcnt_q  <= BW'(TICK_FAST - 1);
    end else if (bcnt_q == '0) begin
      blink_q <= ~blink_q;
      bcnt_q  <= BW'(TICK_FAST - 1);
    end else begin
      bcnt_q  <= bcnt_q - BW'(1);
    end
  end
  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  // Output logic
  logic [16:0] ppl_w;
  always_comb begin
    // Shift one position wider and drop bit 0 so pos=0 and pos=15 clip cleanly.
    ppl_w = 17'h7 << pos_q;
    led   = (blink ? 16'h0000 : ppl_w[16:1])
          | (16'h8000 >> edge_hi) | (16'h0001 << edge_lo);
    state = state_q;
    speed = speed_q;
    score = score_q;
    lose  = (state_q == LOST);
  end

endmodule

// File: tb/tb_cliff_game_seq.sv
module tb_cliff_game_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_p, left_p, right_p, up_p, down_p;
  logic [2:0]  edge_hi, edge_lo;
  logic [15:0] led;
  logic [1:0]  state;
  logic [1:0]  speed;
  logic [15:0] score;
  logic        lose;

  int checks = 0;
  int errors = 0;

  localparam int S_ST = 0, S_SP = 1, S_SC = 2, S_LS = 3, S_LED = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;
  exp_t sb[$];

  cliff_game_seq #(
    .TICK_SLOW(8), .TICK_MED(4), .TICK_FAST(2), .START_IDX(7)
  ) dut (
    .clk(clk), .reset(reset),
    .start_p(start_p), .left_p(left_p), .right_p(right_p),
    .up_p(up_p), .down_p(down_p),
    .edge_hi(edge_hi), .edge_lo(edge_lo),
    .led(led), .state(state), .speed(speed), .score(score), .lose(lose)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  // Expected display built bit by bit from the geometry description.
  function automatic logic [15:0] mled(input int p, input int eh, input int el, input bit hide);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (!hide && i >= p - 1 && i <= p + 1) r[i] = 1'b1;
      if (i == 15 - eh || i == el) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_ST:    return {14'd0, state};
      S_SP:    return {14'd0, speed};
      S_SC:    return score;
      S_LS:    return {15'd0, lose};
      default: return led;
    endcase
  endfunction

  task automatic ex(input string tag, input int sel, input logic [15:0] e);
    exp_t x;
    x.tag = tag; x.sel = sel; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      obs = observe(x.sel);
      checks++;
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
      end
    end
  endtask

  // Inputs applied at a falling edge, held across one rising edge.
  task automatic drive(input bit s, input bit l, input bit r, input bit u, input bit d);
    start_p = s; left_p = l; right_p = r; up_p = u; down_p = d;
    @(posedge clk);
    #1;
    start_p = 0; left_p = 0; right_p = 0; up_p = 0; down_p = 0;
    @(negedge clk);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    start_p = 0; left_p = 0; right_p = 0; up_p = 0; down_p = 0;
    edge_hi = 3'd0; edge_lo = 3'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ex("rst_state", S_ST, 16'd0); ex("rst_led", S_LED, 16'h81C1);
    ex("rst_speed", S_SP, 16'd0); ex("rst_score", S_SC, 16'd0);
    ex("rst_lose", S_LS, 16'd0);
    check_out();

    // Run to pos 10, then reset asynchronously mid-cycle.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    step(6);  ex("run0_pos7", S_LED, mled(7, 0, 0, 0)); check_out();
    step(1);  ex("run0_pos8", S_LED, mled(8, 0, 0, 0)); check_out();
    step(16); ex("run0_pos10", S_LED, mled(10, 0, 0, 0));
    ex("run0_score", S_SC, 16'd3); ex("run0_state", S_ST, 16'd1); check_out();
    #2 reset = 1'b1;
    #1;
    ex("arst_state", S_ST, 16'd0); ex("arst_led", S_LED, 16'h81C1);
    ex("arst_score", S_SC, 16'd0); ex("arst_speed", S_SP, 16'd0);
    check_out();
    @(negedge clk);
    reset = 1'b0;

    // IDLE moves with clamping.
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 0);
    ex("idle_sat14", S_LED, mled(14, 0, 0, 0)); check_out();
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 0, 0);
    ex("idle_sat1", S_LED, mled(1, 0, 0, 0)); check_out();
    drive(0, 1, 1, 0, 0);
    ex("idle_lr_left_wins", S_LED, mled(2, 0, 0, 0)); check_out();
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0);
    ex("idle_back7", S_LED, mled(7, 0, 0, 0)); check_out();

    // Walk into the left cliff.
    edge_hi = 3'd2;
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    step(6); ex("cliff_pos7", S_LED, mled(7, 2, 0, 0)); check_out();
    step(1); ex("cliff_pos8", S_LED, mled(8, 2, 0, 0)); check_out();
    for (int p = 9; p <= 13; p++) begin
      step(8);
      ex("cliff_walk", S_LED, mled(p, 2, 0, 0));
      check_out();
    end
    ex("cliff_still_run", S_ST, 16'd1); ex("cliff_lose0", S_LS, 16'd0); check_out();
    step(1);
    ex("cliff_lost", S_ST, 16'd2); ex("cliff_lose1", S_LS, 16'd1);
    ex("cliff_score", S_SC, 16'd6); ex("cliff_led", S_LED, mled(13, 2, 0, 0));
    check_out();

    // Speed adjustment while LOST.
    drive(0, 0, 0, 1, 0); ex("spd_up1", S_SP, 16'd1); check_out();
    drive(0, 0, 0, 1, 0); ex("spd_up2", S_SP, 16'd2); check_out();
    drive(0, 0, 0, 1, 0); ex("spd_sat2", S_SP, 16'd2); check_out();
    drive(0, 0, 0, 1, 1); ex("spd_updn", S_SP, 16'd2); check_out();
    drive(0, 0, 0, 0, 1); ex("spd_dn1", S_SP, 16'd1); check_out();
    drive(0, 0, 0, 0, 1); drive(0, 0, 0, 0, 1);
    ex("spd_sat0", S_SP, 16'd0); check_out();
    step(5);
    ex("lost_frozen_led", S_LED, mled(13, 2, 0, 0)); ex("lost_frozen_sc", S_SC, 16'd6);
    check_out();
    drive(1, 0, 0, 0, 0);
    ex("lost_to_idle", S_ST, 16'd0); ex("lost_idle_pos", S_LED, mled(7, 2, 0, 0));
    ex("lost_idle_score", S_SC, 16'd6); check_out();
    edge_hi = 3'd0;

    // RUN with dir=STOP; start+left together ignores the move.
    drive(1, 1, 0, 0, 0);
    ex("stop_run", S_ST, 16'd1); ex("stop_score0", S_SC, 16'd0);
    ex("stop_pos", S_LED, mled(7, 0, 0, 0)); check_out();
    step(50);
    ex("stop50_score", S_SC, 16'd0); ex("stop50_pos", S_LED, mled(7, 0, 0, 0));
    check_out();

    // Period change lands at the next reload only.
    drive(0, 1, 0, 1, 0); ex("per_spd1", S_SP, 16'd1); check_out();
    step(4); ex("per_a7", S_LED, mled(7, 0, 0, 0)); check_out();
    step(1); ex("per_a8", S_LED, mled(8, 0, 0, 0)); check_out();
    step(3); ex("per_b8", S_LED, mled(8, 0, 0, 0)); check_out();
    step(1); ex("per_b9", S_LED, mled(9, 0, 0, 0)); check_out();
    drive(0, 0, 0, 1, 0); ex("per_spd2", S_SP, 16'd2); check_out();
    step(2); ex("per_c9", S_LED, mled(9, 0, 0, 0)); check_out();
    step(1); ex("per_c10", S_LED, mled(10, 0, 0, 0)); check_out();
    step(1); ex("per_d10", S_LED, mled(10, 0, 0, 0)); check_out();
    step(1); ex("per_d11", S_LED, mled(11, 0, 0, 0));
    ex("per_score", S_SC, 16'd4); check_out();
    drive(1, 0, 0, 0, 0);
    ex("abort_state", S_ST, 16'd0); ex("abort_pos", S_LED, mled(7, 0, 0, 0));
    ex("abort_score_held", S_SC, 16'd4); check_out();
    drive(0, 0, 0, 0, 1); drive(0, 0, 0, 0, 1);
    ex("spd_back0", S_SP, 16'd0); check_out();

    // Right cliff moved onto the group mid-run.
    drive(1, 0, 0, 0, 0);
    ex("lo_run", S_ST, 16'd1); check_out();
    edge_lo = 3'd7;
    step(1);
    ex("lo_lost", S_ST, 16'd2); ex("lo_lose", S_LS, 16'd1); check_out();
    for (int k = 0; k < 6; k++) begin
`ifdef CLIFF_BLINK_EN
      ex("lost_led", S_LED, mled(7, 0, 7, ((k / 2) % 2) == 1));
`else
      ex("lost_led", S_LED, mled(7, 0, 7, 0));
`endif
      check_out();
      step(1);
    end
    drive(1, 0, 0, 0, 0);
    ex("final_idle", S_ST, 16'd0); ex("final_lose", S_LS, 16'd0);
    ex("final_led", S_LED, mled(7, 0, 7, 0)); check_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
